// File: rtl/issue_queue.sv
// issue_queue: age-ordered, compacting issue queue with tag wakeup.
// Slot 0 holds the oldest micro-op. Occupied slots are always contiguous
// from 0 to count-1. Each edge removes the issued slot, shifts the younger
// slots down one, applies wakeup to every retained slot, and appends any
// dispatch at the new tail.
// Optional feature: define ISSUE_QUEUE_DISPATCH_BYPASS_EN so that a source
// tag matching a same-cycle wakeup is stored already ready at dispatch.
module issue_queue #(
  parameter int DEPTH            = 8,
  parameter int NUM_WAKEUP_PORTS = 2,
  parameter int PREG_W           = 7,
  parameter int CTRL_W           = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [PREG_W-1:0]                  disp_src1,
  input  logic [PREG_W-1:0]                  disp_src2,
  input  logic                               disp_p1,
  input  logic                               disp_p2,
  input  logic [CTRL_W-1:0]                  disp_ctrl,
  input  logic [NUM_WAKEUP_PORTS-1:0]        wakeup_valid,
  input  logic [NUM_WAKEUP_PORTS*PREG_W-1:0] wakeup_pdst,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [PREG_W-1:0]                  issue_src1,
  output logic [PREG_W-1:0]                  issue_src2,
  output logic [CTRL_W-1:0]                  issue_ctrl,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, p1_q, p2_q;
  logic [PREG_W-1:0] src1_q [DEPTH];
  logic [PREG_W-1:0] src2_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CNT_W-1:0]  count_q;

  logic [DEPTH-1:0]  valid_n, p1_n, p2_n;
  logic [PREG_W-1:0] src1_n [DEPTH];
  logic [PREG_W-1:0] src2_n [DEPTH];
  logic [CTRL_W-1:0] ctrl_n [DEPTH];
  logic [CNT_W-1:0]  count_n;

  logic [IDX_W-1:0]  sel;
  logic              found;
  logic              issue_fire;
  logic              disp_fire;
  logic [CNT_W-1:0]  wr_idx;

  // True when any valid wakeup port broadcasts the given tag.
  function automatic logic woken(input logic [PREG_W-1:0] tag,
                                 input logic [NUM_WAKEUP_PORTS-1:0] wv,
                                 input logic [NUM_WAKEUP_PORTS*PREG_W-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKEUP_PORTS; k++)
      if (wv[k] && (wp[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  // Oldest-first select: the descending scan leaves the lowest ready index.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (valid_q[i] && p1_q[i] && p2_q[i]) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign count       = count_q;
  assign disp_ready  = (count_q < CNT_W'(DEPTH));
  assign issue_valid = found && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign disp_fire   = disp_valid && disp_ready && !flush;
  assign issue_src1  = issue_valid ? src1_q[sel] : '0;
  assign issue_src2  = issue_valid ? src2_q[sel] : '0;
  assign issue_ctrl  = issue_valid ? ctrl_q[sel] : '0;

  // Next slot image: compact past the issued slot, wake retained slots, append dispatch.
  always_comb begin
    logic shift;
    wr_idx = count_q - CNT_W'(issue_fire);
    for (int i = 0; i < DEPTH-1; i++) begin
      shift      = issue_fire && (i >= int'(sel));
      valid_n[i] = shift ? valid_q[i+1] : valid_q[i];
      p1_n[i]    = shift ? p1_q[i+1]    : p1_q[i];
      p2_n[i]    = shift ? p2_q[i+1]    : p2_q[i];
      src1_n[i]  = shift ? src1_q[i+1]  : src1_q[i];
      src2_n[i]  = shift ? src2_q[i+1]  : src2_q[i];
      ctrl_n[i]  = shift ? ctrl_q[i+1]  : ctrl_q[i];
    end
    // The top slot always vacates when anything issues.
    valid_n[DEPTH-1] = issue_fire ? 1'b0 : valid_q[DEPTH-1];
    p1_n[DEPTH-1]    = issue_fire ? 1'b0 : p1_q[DEPTH-1];
    p2_n[DEPTH-1]    = issue_fire ? 1'b0 : p2_q[DEPTH-1];
    src1_n[DEPTH-1]  = src1_q[DEPTH-1];
    src2_n[DEPTH-1]  = src2_q[DEPTH-1];
    ctrl_n[DEPTH-1]  = ctrl_q[DEPTH-1];

    for (int i = 0; i < DEPTH; i++) begin
      p1_n[i] = valid_n[i] && (p1_n[i] || woken(src1_n[i], wakeup_valid, wakeup_pdst));
      p2_n[i] = valid_n[i] && (p2_n[i] || woken(src2_n[i], wakeup_valid, wakeup_pdst));
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && (i == int'(wr_idx))) begin
        valid_n[i] = 1'b1;
        src1_n[i]  = disp_src1;
        src2_n[i]  = disp_src2;
        ctrl_n[i]  = disp_ctrl;
`ifdef ISSUE_QUEUE_DISPATCH_BYPASS_EN
        p1_n[i]    = disp_p1 || woken(disp_src1, wakeup_valid, wakeup_pdst);
        p2_n[i]    = disp_p2 || woken(disp_src2, wakeup_valid, wakeup_pdst);
`else
        p1_n[i]    = disp_p1;
        p2_n[i]    = disp_p2;
`endif
      end
    end

    count_n = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);

    if (flush) begin
      valid_n = '0;
      p1_n    = '0;
      p2_n    = '0;
      count_n = '0;
    end
  end

  // Slot and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src1_q[i] <= '0;
        src2_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_n;
      p1_q    <= p1_n;
      p2_q    <= p2_n;
      count_q <= count_n;
      for (int i = 0; i < DEPTH; i++) begin
        src1_q[i] <= src1_n[i];
        src2_q[i] <= src2_n[i];
        ctrl_q[i] <= ctrl_n[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed scenarios plus random traffic against a
// queue-based reference model of the issue queue.
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int NWP   = 2;
  localparam int PW    = 7;
  localparam int CW    = 8;
`ifdef ISSUE_QUEUE_DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush, disp_valid, disp_ready, disp_p1, disp_p2;
  logic [PW-1:0] disp_src1, disp_src2, issue_src1, issue_src2;
  logic [CW-1:0] disp_ctrl, issue_ctrl;
  logic [NWP-1:0] wakeup_valid;
  logic [NWP*PW-1:0] wakeup_pdst;
  logic issue_valid, issue_ready;
  logic [3:0] count;

  issue_queue #(.DEPTH(DEPTH), .NUM_WAKEUP_PORTS(NWP), .PREG_W(PW), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_p1(disp_p1), .disp_p2(disp_p2), .disp_ctrl(disp_ctrl),
    .wakeup_valid(wakeup_valid), .wakeup_pdst(wakeup_pdst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_ctrl(issue_ctrl),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] s1, s2;
    logic          p1, p2;
    logic [CW-1:0] ctrl;
  } ent_t;

  ent_t model[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input logic [PW-1:0] tag);
    logic h;
    h = 1'b0;
    for (int k = 0; k < NWP; k++)
      if (wakeup_valid[k] && wakeup_pdst[k*PW +: PW] == tag) h = 1'b1;
    return h;
  endfunction

  task automatic idle();
    flush = 0; disp_valid = 0; disp_p1 = 0; disp_p2 = 0;
    disp_src1 = '0; disp_src2 = '0; disp_ctrl = '0;
    wakeup_valid = '0; wakeup_pdst = '0; issue_ready = 0;
  endtask

  task automatic disp(input logic [PW-1:0] s1, input logic p1,
                      input logic [PW-1:0] s2, input logic p2, input logic [CW-1:0] c);
    disp_valid = 1; disp_src1 = s1; disp_p1 = p1; disp_src2 = s2; disp_p2 = p2; disp_ctrl = c;
  endtask

  task automatic wake(input int port, input logic [PW-1:0] tag);
    wakeup_valid[port] = 1'b1;
    wakeup_pdst[port*PW +: PW] = tag;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance both.
  task automatic step();
    int  idx;
    bit  iv, ifire, dfire;
    ent_t e;
    @(negedge clk);
    idx = -1;
    for (int i = 0; i < model.size(); i++)
      if (model[i].p1 && model[i].p2) begin idx = i; break; end
    iv = (idx >= 0) && !flush;
    chk("count", 32'(count), 32'(model.size()));
    chk("disp_ready", 32'(disp_ready), 32'(model.size() < DEPTH));
    chk("issue_valid", 32'(issue_valid), 32'(iv));
    chk("issue_src1", 32'(issue_src1), iv ? 32'(model[idx].s1) : 32'd0);
    chk("issue_src2", 32'(issue_src2), iv ? 32'(model[idx].s2) : 32'd0);
    chk("issue_ctrl", 32'(issue_ctrl), iv ? 32'(model[idx].ctrl) : 32'd0);
    ifire = iv && issue_ready;
    dfire = disp_valid && (model.size() < DEPTH) && !flush;
    @(posedge clk);
    if (flush) model.delete();
    else begin
      if (ifire) model.delete(idx);
      foreach (model[i]) begin
        if (hit(model[i].s1)) model[i].p1 = 1'b1;
        if (hit(model[i].s2)) model[i].p2 = 1'b1;
      end
      if (dfire) begin
        e.s1 = disp_src1; e.s2 = disp_src2; e.ctrl = disp_ctrl;
        e.p1 = disp_p1 || (BYP && hit(disp_src1));
        e.p2 = disp_p2 || (BYP && hit(disp_src2));
        model.push_back(e);
      end
    end
    #1;
    idle();
  endtask

  initial begin
    reset = 0;
    idle();
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    chk("rst_issue_src1", 32'(issue_src1), 0);
    #6 reset = 1;
    #1;

    // Wakeup makes a pending micro-op issuable exactly one cycle later.
    disp(7'd5, 0, 7'd6, 1, 8'hA5); step();
    step();
    wake(0, 7'd5); step();
    #3;
    chk("wake_issue_valid", 32'(issue_valid), 1);
    chk("wake_issue_src1", 32'(issue_src1), 5);
    issue_ready = 1; step();

    // Oldest ready first; the unready head stays put.
    disp(7'd10, 0, 7'd20, 1, 8'h01); step();
    disp(7'd11, 1, 7'd21, 1, 8'h02); step();
    disp(7'd12, 1, 7'd22, 1, 8'h03); step();
    #3;
    chk("age_count3", 32'(count), 3);
    chk("age_first", 32'(issue_src1), 11);
    issue_ready = 1; step();
    #3;
    chk("age_count2", 32'(count), 2);
    chk("age_second", 32'(issue_src1), 12);
    issue_ready = 1; step();
    #3;
    chk("age_count1", 32'(count), 1);
    chk("age_none", 32'(issue_valid), 0);
    flush = 1; step();

    // Full queue: issuing does not reopen dispatch in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin disp(7'(30+i), 1, 7'd1, 1, 8'(i)); step(); end
    #3;
    chk("full_count", 32'(count), 8);
    chk("full_ready", 32'(disp_ready), 0);
    disp(7'd50, 1, 7'd51, 1, 8'hEE); issue_ready = 1; step();
    #3;
    chk("full_after_issue", 32'(count), 7);
    disp(7'd50, 1, 7'd51, 1, 8'hEE); step();
    #3;
    chk("full_refill", 32'(count), 8);
    flush = 1; step();

    // Dispatch with a same-cycle wakeup of its source.
    disp(7'd9, 0, 7'd3, 1, 8'h99); wake(1, 7'd9); step();
    #3;
    chk("bypass_issue_valid", 32'(issue_valid), 32'(BYP));
    step();
    wake(0, 7'd9); step();
    #3;
    chk("late_wake_valid", 32'(issue_valid), 1);
    flush = 1; step();

    // Flush overrides dispatch and issue.
    for (int i = 0; i < 5; i++) begin disp(7'(40+i), 1, 7'd2, 1, 8'(i)); step(); end
    flush = 1; disp(7'd60, 1, 7'd61, 1, 8'h11); issue_ready = 1;
    #3;
    chk("flush_issue_valid", 32'(issue_valid), 0);
    step();
    #3;
    chk("flush_count", 32'(count), 0);

    // Asynchronous reset mid-cycle with four entries.
    for (int i = 0; i < 4; i++) begin disp(7'(70+i), 0, 7'd2, 1, 8'(i)); step(); end
    #1 reset = 0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_issue_valid", 32'(issue_valid), 0);
    chk("async_disp_ready", 32'(disp_ready), 1);
    model.delete();
    #1 reset = 1;
    disp(7'd77, 1, 7'd78, 1, 8'h7E); step();
    #3;
    chk("post_reset_slot0", 32'(issue_src1), 77);

    // Random traffic with a small tag space so wakeups land often.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0)
        disp(7'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
             7'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 8'($urandom));
      for (int k = 0; k < NWP; k++)
        if ($urandom_range(0, 1) == 1) wake(k, 7'($urandom_range(0, 15)));
      issue_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
